// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared types and helpers for the memory request port.
package mem_req_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic int maskWidth(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// mem_resp_fifo: synchronous FIFO holding captured read data until the consumer takes it.
// Output is read straight from storage (no bypass); it reads as zero while empty.
module mem_resp_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_comb begin
        rd_d  = !do_pop ? rd_q : (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
        wr_d  = !do_push ? wr_q : (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/mem_req_port.sv
// mem_req_port: request front end for one memory port; issues reads/masked writes and
// returns read data in order, with credit-based flow control so no read data is dropped.
module mem_req_port
    import mem_req_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int LENGTH     = 32,
    parameter int DELAY      = 1,
    parameter int RESP_DEPTH = 4,
    localparam int MASK = maskWidth(WIDTH),
    localparam int AW   = $clog2(LENGTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             reqValid_i,
    output logic             reqReady_o,
    input  logic             reqWrite_i,
    input  logic [AW-1:0]    reqAddr_i,
    input  logic [WIDTH-1:0] reqData_i,
    input  logic [MASK-1:0]  reqStrb_i,
    output logic             respValid_o,
    input  logic             respReady_i,
    output logic [WIDTH-1:0] respData_o,
    output logic [AW-1:0]    memAddr_o,
    output logic [WIDTH-1:0] memData_o,
    output logic             memEn_o,
    output logic [MASK-1:0]  memWr_o,
    input  logic [WIDTH-1:0] memData_i
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int SW = $clog2(DELAY + RESP_DEPTH + 1);

    typedef struct packed {
        op_e              op;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic [MASK-1:0]  strb;
    } req_t;

    req_t             req;
    logic [DELAY-1:0] vld_q, vld_d;
    logic [SW-1:0]    inflight;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] fifo_data;
    logic             acc, rd, full, empty;

    assign req = '{op: op_e'(reqWrite_i), addr: reqAddr_i, data: reqData_i, strb: reqStrb_i};

    always_comb begin
        inflight = '0;
        for (int i = 0; i < DELAY; i++) inflight += SW'(vld_q[i]);
    end

    // Credit uses registered state only; full is implied by the sum but keeps the FIFO safe.
    assign reqReady_o = !rst_i && !full && (inflight + SW'(count) < SW'(RESP_DEPTH));
    assign acc        = reqValid_i && reqReady_o;
    assign rd         = acc && req.op == OP_READ;
    assign memEn_o    = rd || (acc && |req.strb);
    assign memWr_o    = (acc && req.op == OP_WRITE) ? req.strb : '0;
    assign memAddr_o  = acc ? req.addr : '0;
    assign memData_o  = acc ? req.data : '0;

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = rd;
    end

    always_ff @(posedge clk_i) begin
        vld_q <= rst_i ? '0 : vld_d;
    end

    assign respValid_o = !rst_i && !empty;
    assign respData_o  = rst_i ? '0 : fifo_data;

    mem_resp_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(RESP_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (vld_q[DELAY-1]),
        .data_i (memData_i),
        .pop_i  (respValid_o && respReady_i),
        .data_o (fifo_data),
        .count_o(count),
        .full_o (full),
        .empty_o(empty)
    );

endmodule

// File: tb/tb_mem_req_port.sv
// tb_mem_req_port: drives mem_req_port against a behavioural memory and checks it
// against a queue-based model of accepted reads and their data-ready times.
module tb_mem_req_port;

    localparam int W   = 16;
    localparam int LEN = 32;
    localparam int DLY = 2;
    localparam int DEP = 4;
    localparam int MW  = 2;
    localparam int AW  = 5;

    logic          clk, rst;
    logic          req_valid, req_ready, req_write, resp_valid, resp_ready, mem_en;
    logic [AW-1:0] req_addr, mem_addr;
    logic [W-1:0]  req_data, resp_data, mem_data_o, mem_data_i;
    logic [MW-1:0] req_strb, mem_wr;

    int checks = 0;
    int fails  = 0;

    mem_req_port #(.WIDTH(W), .LENGTH(LEN), .DELAY(DLY), .RESP_DEPTH(DEP)) dut (
        .clk_i(clk), .rst_i(rst),
        .reqValid_i(req_valid), .reqReady_o(req_ready), .reqWrite_i(req_write),
        .reqAddr_i(req_addr), .reqData_i(req_data), .reqStrb_i(req_strb),
        .respValid_o(resp_valid), .respReady_i(resp_ready), .respData_o(resp_data),
        .memAddr_o(mem_addr), .memData_o(mem_data_o), .memEn_o(mem_en),
        .memWr_o(mem_wr), .memData_i(mem_data_i)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Attached memory: masked writes, reads visible DLY edges after the address edge.
    logic [W-1:0] mem [LEN];
    logic [W-1:0] pipe [DLY];
    always @(posedge clk) begin
        if (mem_en)
            for (int b = 0; b < MW; b++)
                if (mem_wr[b]) mem[mem_addr][8*b +: 8] <= mem_data_o[8*b +: 8];
        pipe[0] <= mem[mem_addr];
        for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data_i = pipe[DLY-1];

    // Reference model: every accepted read waits in q until popped; its data is
    // presentable once the edge counter reaches its accept edge plus DLY.
    typedef struct {
        logic [W-1:0] d;
        int           t;
    } exp_t;
    exp_t         q[$];
    logic [W-1:0] ref_mem [LEN];
    int           e = 0;

    function automatic bit exp_ready();
        return !rst && q.size() < DEP;
    endfunction
    function automatic bit exp_valid();
        return !rst && q.size() > 0 && q[0].t <= e;
    endfunction
    function automatic logic [W-1:0] exp_data();
        return q.size() > 0 ? q[0].d : '0;
    endfunction

    always @(posedge clk) begin
        bit rdy, vld;
        rdy = exp_ready();
        vld = exp_valid();
        e++;
        if (rst) q.delete();
        else begin
            if (vld && resp_ready) void'(q.pop_front());
            if (req_valid && rdy) begin
                if (req_write) begin
                    for (int b = 0; b < MW; b++)
                        if (req_strb[b]) ref_mem[req_addr][8*b +: 8] = req_data[8*b +: 8];
                end else q.push_back('{ref_mem[req_addr], e + DLY});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (dut.u_fifo.push_i && dut.u_fifo.full_o) begin
                fails++;
                $display("FAIL fifo_overflow: push with full FIFO at edge %0d, required no push when full", e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 1; req_write = 0; req_addr = 5; req_data = 16'h5555; req_strb = 2'b11;
        resp_ready = 1;
        tick(); tick(); #1;
        checks++;
        if (req_ready !== 1'b0 || mem_en !== 1'b0 || mem_wr !== 2'b00 || mem_addr !== 5'd0 || mem_data_o !== 16'h0) begin
            fails++;
            $display("FAIL reset_req_side: ready=%b en=%b wr=%b addr=%0d data=%h, required all zero",
                     req_ready, mem_en, mem_wr, mem_addr, mem_data_o);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 16'h0) begin
            fails++;
            $display("FAIL reset_resp_side: valid=%b data=%h, required 0/0000", resp_valid, resp_data);
        end
        req_valid = 0; rst = 0; #1;
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_single_read();
        tick();
        req_valid = 1; req_write = 0; req_addr = 5; resp_ready = 1; #1;
        checks++;
        if (req_ready !== 1'b1 || mem_en !== 1'b1 || mem_wr !== 2'b00 || mem_addr !== 5'd5) begin
            fails++;
            $display("FAIL single_issue: ready=%b en=%b wr=%b addr=%0d, required 1/1/00/5",
                     req_ready, mem_en, mem_wr, mem_addr);
        end
        tick();
        req_valid = 0;
        for (int k = 0; k <= DLY + 1; k++) begin
            checks++;
            if (resp_valid !== (k == DLY) || resp_valid !== exp_valid()) begin
                fails++;
                $display("FAIL single_latency: %0d edges after accept valid=%b, required %b", k, resp_valid, k == DLY);
            end
            if (k == DLY) begin
                checks++;
                if (resp_data !== 16'hBEEF) begin
                    fails++;
                    $display("FAIL single_data: got %h, required beef", resp_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_byte_write();
        int n = 0;
        req_valid = 1; req_write = 1; req_addr = 3; req_data = 16'h1234; req_strb = 2'b01; #1;
        checks++;
        if (mem_en !== 1'b1 || mem_wr !== 2'b01 || mem_addr !== 5'd3 || mem_data_o !== 16'h1234) begin
            fails++;
            $display("FAIL bytewrite_issue: en=%b wr=%b addr=%0d data=%h, required 1/01/3/1234",
                     mem_en, mem_wr, mem_addr, mem_data_o);
        end
        tick();
        req_write = 0;
        tick();
        req_valid = 0;
        while (!resp_valid && n < 10) begin tick(); n++; end
        checks++;
        if (!resp_valid || resp_data !== 16'hFF34 || resp_data !== exp_data()) begin
            fails++;
            $display("FAIL bytewrite_readback: valid=%b data=%h, required 1/ff34", resp_valid, resp_data);
        end
        tick();
    endtask

    task automatic test_zero_strobe();
        int n = 0;
        logic [W-1:0] orig;
        orig = ref_mem[7];
        req_valid = 1; req_write = 1; req_addr = 7; req_data = ~orig; req_strb = 2'b00; #1;
        checks++;
        if (req_ready !== 1'b1 || mem_en !== 1'b0 || mem_wr !== 2'b00) begin
            fails++;
            $display("FAIL zerostrb_issue: ready=%b en=%b wr=%b, required 1/0/00", req_ready, mem_en, mem_wr);
        end
        tick();
        req_valid = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (resp_valid !== 1'b0) begin
                fails++;
                $display("FAIL zerostrb_noresp: cycle %0d valid=%b, required 0", k, resp_valid);
            end
            tick();
        end
        req_valid = 1; req_write = 0;
        tick();
        req_valid = 0;
        while (!resp_valid && n < 10) begin tick(); n++; end
        checks++;
        if (!resp_valid || resp_data !== orig) begin
            fails++;
            $display("FAIL zerostrb_unchanged: valid=%b data=%h, required 1/%h", resp_valid, resp_data, orig);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int issued = 0, pops = 0;
        resp_ready = 0; req_write = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = issued < 6; req_addr = AW'(8 + issued); #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                fails++;
                $display("FAIL bp_ready_stall: cycle %0d ready=%b, required %b", c, req_ready, exp_ready());
            end
            if (req_valid && req_ready) issued++;
            tick();
        end
        checks++;
        if (issued != 4 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept_count: accepted=%0d ready=%b, required 4/0", issued, req_ready);
        end
        resp_ready = 1;
        for (int c = 0; c < 30 && pops < 6; c++) begin
            req_valid = issued < 6; req_addr = AW'(8 + issued); #1;
            checks++;
            if (req_ready !== exp_ready() || resp_valid !== exp_valid()) begin
                fails++;
                $display("FAIL bp_drain_flags: ready=%b valid=%b, required %b/%b",
                         req_ready, resp_valid, exp_ready(), exp_valid());
            end
            if (resp_valid) begin
                checks++;
                if (resp_data !== ref_mem[8 + pops]) begin
                    fails++;
                    $display("FAIL bp_order: response %0d data=%h, required %h", pops, resp_data, ref_mem[8 + pops]);
                end
                pops++;
            end
            if (req_valid && req_ready) issued++;
            tick();
        end
        checks++;
        if (issued != 6 || pops != 6) begin
            fails++;
            $display("FAIL bp_complete: accepted=%0d responses=%0d, required 6/6", issued, pops);
        end
    endtask

    task automatic test_streaming();
        int issued = 0, pops = 0, first_acc = -1, first_resp = -1;
        resp_ready = 1; req_write = 0;
        for (int c = 0; c < 60 && pops < 16; c++) begin
            req_valid = issued < 16; req_addr = AW'(issued); #1;
            if (req_valid) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_ready: cycle %0d ready=%b, required 1", c, req_ready);
                end
            end
            checks++;
            if (resp_valid !== exp_valid()) begin
                fails++;
                $display("FAIL stream_valid: cycle %0d valid=%b, required %b", c, resp_valid, exp_valid());
            end
            if (resp_valid) begin
                checks++;
                if (resp_data !== ref_mem[pops]) begin
                    fails++;
                    $display("FAIL stream_order: response %0d data=%h, required %h", pops, resp_data, ref_mem[pops]);
                end
                if (first_resp < 0) first_resp = c;
                pops++;
            end
            if (req_valid && req_ready) begin
                if (first_acc < 0) first_acc = c;
                issued++;
            end
            tick();
        end
        checks++;
        if (pops != 16 || first_resp - first_acc != DLY + 1) begin
            fails++;
            $display("FAIL stream_summary: responses=%0d first latency=%0d, required 16/%0d",
                     pops, first_resp - first_acc, DLY + 1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit acc_m;
            req_valid = ($urandom % 4) != 0; req_write = ($urandom % 3) == 0;
            req_addr = AW'($urandom); req_data = W'($urandom); req_strb = MW'($urandom);
            resp_ready = ($urandom % 4) != 0; #1;
            acc_m = req_valid && exp_ready();
            checks++;
            if (req_ready !== exp_ready() || resp_valid !== exp_valid() || (resp_valid && resp_data !== exp_data())) begin
                fails++;
                $display("FAIL rand_resp: cycle %0d ready=%b valid=%b data=%h, required %b/%b/%h",
                         c, req_ready, resp_valid, resp_data, exp_ready(), exp_valid(), exp_data());
            end
            checks++;
            if (mem_en !== (acc_m && (!req_write || req_strb != 0)) ||
                mem_wr !== ((acc_m && req_write) ? req_strb : 2'b00) ||
                mem_addr !== (acc_m ? req_addr : 5'd0) || mem_data_o !== (acc_m ? req_data : 16'h0)) begin
                fails++;
                $display("FAIL rand_issue: cycle %0d en=%b wr=%b addr=%0d data=%h, accept=%b write=%b strb=%b",
                         c, mem_en, mem_wr, mem_addr, mem_data_o, acc_m, req_write, req_strb);
            end
            tick();
        end
        req_valid = 0; resp_ready = 1;
        for (int c = 0; c < 20 && q.size() > 0; c++) tick();
    endtask

    task automatic test_reset_midflight();
        resp_ready = 0; req_write = 0; req_valid = 1;
        req_addr = 1; tick();
        req_addr = 2; tick();
        req_addr = 4; tick();
        req_valid = 0; #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== ref_mem[1]) begin
            fails++;
            $display("FAIL midflight_setup: valid=%b data=%h, required 1/%h", resp_valid, resp_data, ref_mem[1]);
        end
        rst = 1;
        tick();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL midflight_in_reset: valid=%b ready=%b, required 0/0", resp_valid, req_ready);
        end
        rst = 0; resp_ready = 1; #1;
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL midflight_ready: got %b, required 1", req_ready);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                fails++;
                $display("FAIL midflight_discard: cycle %0d valid=%b ready=%b, required 0/1", k, resp_valid, req_ready);
            end
        end
    endtask

    initial begin
        rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_data = 0; req_strb = 0; resp_ready = 0;
        for (int i = 0; i < LEN; i++) ref_mem[i] = W'($urandom);
        ref_mem[5] = 16'hBEEF;
        ref_mem[3] = 16'hFFFF;
        for (int i = 0; i < LEN; i++) mem[i] <= ref_mem[i];
        test_reset();
        test_single_read();
        test_byte_write();
        test_zero_strobe();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
